// File: rtl/breakout_pkg.sv
// Shared constants and types for the block store sequencer.
// Contents:
//   DEF_NUM_ROWS - default row count of the attached rotating row store
//   NUM_COLS     - bits per row (store line width)
//   ROW_W        - width of a row index
//   COL_W        - width of a column index
//   ctrl_state_t - sequencer FSM state
//   grant_t      - which requester owns the current transaction
package breakout_pkg;
    localparam int DEF_NUM_ROWS = 16;
    localparam int NUM_COLS     = 13;
    localparam int ROW_W        = $clog2(DEF_NUM_ROWS);
    localparam int COL_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_ACK  = 2'd2
    } ctrl_state_t;

    typedef enum logic {
        GRANT_RD  = 1'b0,
        GRANT_HIT = 1'b1
    } grant_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input alternating arbiter between the renderer and collision logic.
// Ports:
//   clk, nRst       - clock, asynchronous active-low reset
//   en              - grant enable; last_grant only advances when enabled
//   req_rd, req_hit - pending requests
//   valid           - at least one request pending
//   grant           - chosen requester (meaningful when valid)
// On a tie the renderer wins unless it also won the previous grant, so a
// collision request waits for at most one render transaction.
module rr_arb2
    import breakout_pkg::*;
(
    input  logic   clk,
    input  logic   nRst,
    input  logic   en,
    input  logic   req_rd,
    input  logic   req_hit,
    output logic   valid,
    output grant_t grant
);
    grant_t last_grant;

    always_comb begin
        valid = req_rd | req_hit;
        grant = GRANT_RD;
        if (req_rd && req_hit) begin
            grant = (last_grant == GRANT_RD) ? GRANT_HIT : GRANT_RD;
        end else if (req_hit) begin
            grant = GRANT_HIT;
        end
    end

    // Resets to "hit" so the renderer wins the first tie.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            last_grant <= GRANT_HIT;
        end else if (en && valid) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/block_ctrl.sv
// Sequencer and arbiter for the rotating block row store.
// Tracks the row at the store output (head), rotates the store to a target
// row, serves renderer row reads and collision read-modify-write clears, and
// counts cleared blocks (saturating at 255).
// Ports:
//   clk, nRst                   - clock, async active-low reset (shared with store)
//   line / new_line             - head row from store / replacement row to store
//   write_line / next_line      - write head row / rotate store by one row
//   rd_req, rd_row              - renderer request and row (held until rd_ack)
//   rd_ack, rd_data             - one-cycle ack, registered row contents
//   hit_req, hit_row, hit_col   - collision request (held until hit_ack)
//   hit_ack, hit_was_set        - one-cycle ack, block was present before clear
//   cleared                     - cleared block count, saturating
//   busy                        - FSM not in IDLE
//   fsm_state                   - current FSM state, for observation
// Handshake: a requester raises *_req with stable row/col and holds it until
// the one-cycle *_ack; requests are only sampled in IDLE, never during ACK.
module block_ctrl
    import breakout_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [NUM_COLS-1:0] line,
    output logic [NUM_COLS-1:0] new_line,
    output logic              write_line,
    output logic              next_line,
    input  logic              rd_req,
    input  logic [ROW_W-1:0]  rd_row,
    output logic              rd_ack,
    output logic [NUM_COLS-1:0] rd_data,
    input  logic              hit_req,
    input  logic [ROW_W-1:0]  hit_row,
    input  logic [COL_W-1:0]  hit_col,
    output logic              hit_ack,
    output logic              hit_was_set,
    output logic [7:0]        cleared,
    output logic              busy,
    output ctrl_state_t       fsm_state
);
    ctrl_state_t         state;
    logic [ROW_W-1:0]    head;
    logic [ROW_W-1:0]    target_q;
    logic [COL_W-1:0]    col_q;
    grant_t              op_q;

    logic                arb_valid;
    grant_t              arb_grant;

    logic                at_target;
    logic                row_ok;
    logic                col_ok;
    logic [NUM_COLS-1:0] col_mask;
    logic                bit_set;

    rr_arb2 u_arb (
        .clk     (clk),
        .nRst    (nRst),
        .en      (state == ST_IDLE),
        .req_rd  (rd_req),
        .req_hit (hit_req),
        .valid   (arb_valid),
        .grant   (arb_grant)
    );

    // Strobes are driven combinationally in SEEK because the clear must use
    // the head row presented in that same cycle.
    always_comb begin
        at_target  = (head == target_q);
        row_ok     = ({1'b0, target_q} < (ROW_W + 1)'(NUM_ROWS));
        col_ok     = (col_q < COL_W'(NUM_COLS));
        col_mask   = col_ok ? (NUM_COLS'(1) << col_q) : '0;
        bit_set    = |(line & col_mask);
        next_line  = (state == ST_SEEK) && row_ok && !at_target;
        write_line = (state == ST_SEEK) && row_ok && at_target &&
                     (op_q == GRANT_HIT) && bit_set;
        new_line   = write_line ? (line & ~col_mask) : '0;
        busy       = (state != ST_IDLE);
        fsm_state  = state;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= ST_IDLE;
            head        <= '0;
            target_q    <= '0;
            col_q       <= '0;
            op_q        <= GRANT_RD;
            rd_ack      <= 1'b0;
            rd_data     <= '0;
            hit_ack     <= 1'b0;
            hit_was_set <= 1'b0;
            cleared     <= '0;
        end else begin
            rd_ack  <= 1'b0;
            hit_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        op_q     <= arb_grant;
                        target_q <= (arb_grant == GRANT_HIT) ? hit_row : rd_row;
                        col_q    <= hit_col;
                        state    <= ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (!row_ok) begin
                        // Unreachable row: acknowledge without rotating.
                        if (op_q == GRANT_RD) begin
                            rd_data <= '0;
                            rd_ack  <= 1'b1;
                        end else begin
                            hit_was_set <= 1'b0;
                            hit_ack     <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else if (!at_target) begin
                        head <= (head == ROW_W'(NUM_ROWS - 1)) ? '0 : head + 1'b1;
                    end else begin
                        if (op_q == GRANT_RD) begin
                            rd_data <= line;
                            rd_ack  <= 1'b1;
                        end else begin
                            hit_was_set <= write_line;
                            if (write_line && cleared != 8'hFF) begin
                                cleared <= cleared + 8'd1;
                            end
                            hit_ack <= 1'b1;
                        end
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/block_ctrl.md
# block_ctrl

Sequencer and arbiter for the `block_state` rotating row store. It keeps track of which row currently sits at the store's output and rotates the store to any requested row. It shares the store between two requesters: the renderer, which reads whole rows, and the ball-collision logic, which clears single blocks through a read-modify-write. It also keeps a count of cleared blocks for scoring and level-end detection.

## Interface
- `NUM_ROWS`, 16, number of rows in the attached `block_state`. Must match that instance.
- `NUM_COLS`, 13, bits per row. Fixed by the `block_state` line width.
- `clk` in 1: the only clock.
- `nRst` in 1: asynchronous, active-low reset. It must be the same net that drives the `block_state` `nRst`.
- `line` in 13: current head row, from the store.
- `new_line` out 13: replacement row, to the store.
- `write_line` out 1: strobe that writes `new_line` into the head row.
- `next_line` out 1: strobe that rotates the store; head advances to row+1 mod NUM_ROWS.
- `rd_req` in 1: renderer request. Held high until `rd_ack`.
- `rd_row` in 4: row to read. Must be stable while `rd_req` is high.
- `rd_ack` out 1: one-cycle pulse; `rd_data` is valid in the same cycle.
- `rd_data` out 13: row contents, registered. Holds its value until the next read.
- `hit_req` in 1: collision request. Held high until `hit_ack`.
- `hit_row` in 4, `hit_col` in 4: block to clear. Must be stable while `hit_req` is high.
- `hit_ack` out 1: one-cycle pulse.
- `hit_was_set` out 1: valid with `hit_ack`; 1 if the block was present before the clear.
- `cleared` out 8: count of blocks cleared since reset. Saturates at 255.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Row numbering: row 0 is the row presented at `line` after reset. Each `next_line` pulse increments the head pointer `head` modulo NUM_ROWS.
- FSM states: IDLE, SEEK, ACK.
- IDLE:
  - Samples the requests and chooses a grantee; see arbitration below.
  - Latches the target row, the column, and the operation type.
  - Moves to SEEK.
  - With no request pending, stays in IDLE.
- Arbitration:
  - If only one request is pending, that requester is granted.
  - If both are pending, the renderer is granted unless the previous grant also went to the renderer, in which case the collision request is granted. This alternation bounds collision latency to one render transaction.
  - `last_grant` resets to "hit", so the renderer wins the first tie.
- SEEK with `head != target`:
  - Asserts `next_line` and increments `head`.
  - Exactly one rotation per cycle. The shortest path is not required, since rotation is one-directional.
- SEEK with `head == target`:
  - Read: registers `rd_data <= line`.
  - Hit: if `hit_col < NUM_COLS` and `line[hit_col] == 1`, asserts `write_line` with `new_line = line & ~(1<<hit_col)`, registers `hit_was_set <= 1`, and increments `cleared` (saturating). Otherwise it asserts no write and registers `hit_was_set <= 0`.
  - Moves to ACK.
- ACK:
  - Pulses the granted `*_ack` for one cycle, then returns to IDLE.
  - The request lines are ignored during ACK, so a requester that is still holding `req` in that cycle is not served twice.
- Invalid target row (`row >= NUM_ROWS`): no rotation. The request is acknowledged with `rd_data = 0`, or with `hit_was_set = 0` for a hit.
- `write_line` and `next_line` are never asserted in the same cycle.
- `new_line` is 0 whenever `write_line` is low.

## Timing
- Let d = (target − head) mod NUM_ROWS. The request is sampled in IDLE at edge 0; the FSM then spends d rotate cycles and one match cycle in SEEK, and `*_ack` is high in cycle d+2.
- Back-to-back requests: the next request can be sampled in the IDLE cycle that follows ACK.
- Reset values: FSM in IDLE, `head` = 0, `last_grant` = hit, all strobes and acks 0, `rd_data` = 0, `hit_was_set` = 0, `cleared` = 0, `busy` = 0.
- Reset asserted mid-operation: everything returns to reset values immediately. The store resets at the same time, so `head` = 0 remains consistent. A pending request is re-served after reset is released.

## Structure
- Shared package `breakout_pkg` holds `NUM_COLS`, `ROW_W = $clog2(NUM_ROWS)`, and the FSM state enum.
- The single natural sub-module is `rr_arb2`: a two-input arbiter with a `last_grant` register and a grant-enable input.
- `head`, the FSM, and `cleared` stay in `block_ctrl`.

## Test plan
- After reset, read row 0 → `rd_ack` in cycle 2, `rd_data` = 0x0AAF, no `next_line` pulses.
- Read row 5 from head 0 → 5 `next_line` pulses, `rd_ack` in cycle 7, `rd_data` = 0x155A.
- Read row 15, then read row 0 → 15 rotations, then 1 rotation; `rd_data` = 0x1550, then 0x0AAF.
- Hit row 0, column 0 twice → first hit writes 0x0AAE with `hit_was_set` = 1 and `cleared` = 1; second hit asserts no `write_line`, `hit_was_set` = 0, `cleared` stays 1. Repeat with column 13 → acknowledged with no write.
- Raise `rd_req` and `hit_req` together, with `rd_req` re-raised after every ack → grants alternate render, hit, render; no double ack; every `hit_ack` arrives within one render transaction of the request.
- Assert `nRst` in the middle of a SEEK at head 3 → all outputs return to reset values; after release, row 0 reads 0x0AAF.
